// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//   Main control sequencer for the multicycle RV32I core. Each instruction is
//   stepped through fetch, decode, execute, memory and writeback states. The
//   block drives every datapath mux select and write enable, plus the 2-bit
//   ALUOp consumed by the ALU decoder. Instruction and data accesses share a
//   single mem_ready handshake.
//
//   Handshake: a memory access (FETCH, MEMREAD, MEMWRITE) is presented by the
//   current state and held unchanged until mem_ready=1 is seen in that same
//   cycle. The access completes on that rising edge. mem_ready is ignored in
//   every other state.
//
// Ports
//   clk        : core clock, all state changes on the rising edge
//   reset      : synchronous, active-high, forces state to FETCH
//   op         : opcode from the instruction register (stable from DECODE)
//   Zero       : ALU zero flag, sampled only in BEQ
//   mem_ready  : memory completes the current access this cycle
//   PCWrite    : PC register enable
//   AdrSrc     : memory address select, 0=PC, 1=ALUOut/Result
//   MemWrite   : data memory write strobe
//   IRWrite    : instruction register (and OldPC) enable
//   ResultSrc  : 00=ALUOut, 01=Data, 10=ALUResult
//   ALUSrcA    : 00=PC, 01=OldPC, 10=rs1
//   ALUSrcB    : 00=rs2, 01=ImmExt, 10=constant 4
//   ALUOp      : 00=add, 01=branch compare, 10=decode from funct fields
//   ImmSrc     : 00=I, 01=S, 10=B, 11=J
//   RegWrite   : register file write enable
//   instr_done : one-cycle pulse on the last cycle of each instruction
//   illegal_op : one-cycle pulse when DECODE sees an unsupported opcode
//   state_o    : current state (debug)
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         op,
   input  logic               Zero,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               AdrSrc,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUOp,
   output logic [1:0]         ImmSrc,
   output logic               RegWrite,
   output logic               instr_done,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state_o
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = STATE_W'(0),
      S_DECODE   = STATE_W'(1),
      S_MEMADR   = STATE_W'(2),
      S_MEMREAD  = STATE_W'(3),
      S_MEMWB    = STATE_W'(4),
      S_MEMWRITE = STATE_W'(5),
      S_EXECUTER = STATE_W'(6),
      S_ALUWB    = STATE_W'(7),
      S_EXECUTEI = STATE_W'(8),
      S_JAL      = STATE_W'(9),
      S_BEQ      = STATE_W'(10)
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   w_pcupdate;
   logic   w_branch;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   assign state_o = r_state;

   // Immediate format depends only on the opcode, so it is valid in every state.
   always_comb begin
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   always_comb begin
      w_next     = r_state;
      w_pcupdate = 1'b0;
      w_branch   = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;

      case (r_state)
         S_FETCH: begin
            // PC+4 is computed on the ALU while the instruction is read.
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
            IRWrite    = mem_ready;
            w_pcupdate = mem_ready;
            w_next     = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // OldPC + imm precomputes the branch/jump target.
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R:         w_next = S_EXECUTER;
               OP_I:         w_next = S_EXECUTEI;
               OP_JAL:       w_next = S_JAL;
               OP_BEQ:       w_next = S_BEQ;
               default: begin
                  w_next     = S_FETCH;
                  illegal_op = 1'b1;
                  instr_done = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            w_next  = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            w_next = mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            ResultSrc  = 2'b01;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            w_next     = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc     = 1'b1;
            MemWrite   = 1'b1;
            instr_done = mem_ready;
            w_next     = mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECUTER: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
            w_next  = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            w_next     = S_FETCH;
         end
         S_EXECUTEI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
            w_next  = S_ALUWB;
         end
         S_JAL: begin
            // Target from DECODE goes to the PC; ALU forms OldPC+4 for rd.
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            w_pcupdate = 1'b1;
            w_next     = S_ALUWB;
         end
         S_BEQ: begin
            ALUSrcA    = 2'b10;
            ALUOp      = 2'b01;
            w_branch   = 1'b1;
            instr_done = 1'b1;
            w_next     = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase

      PCWrite = w_pcupdate | (w_branch & Zero);

      // During reset nothing may be written; selects already show the fetch
      // path so the datapath is quiet when the first fetch starts.
      if (reset) begin
         PCWrite    = 1'b0;
         IRWrite    = 1'b0;
         MemWrite   = 1'b0;
         RegWrite   = 1'b0;
         instr_done = 1'b0;
         illegal_op = 1'b0;
         AdrSrc     = 1'b0;
         ALUSrcA    = 2'b00;
         ALUSrcB    = 2'b10;
         ALUOp      = 2'b00;
         ResultSrc  = 2'b10;
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//   Self-checking bench for multicycle_control_fsm. The reference model builds,
//   for each instruction, the expected state trace from the instruction class
//   and the chosen stall counts, and predicts per-instruction totals of each
//   write enable. Inputs change on the falling edge; outputs are sampled 1 ns
//   later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

   localparam int W = 4;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset = 1'b1;
   logic [6:0]   op = 7'd0;
   logic         Zero = 1'b0;
   logic         mem_ready = 1'b0;
   logic         PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_op;
   logic [1:0]   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
   logic [W-1:0] state_o;

   multicycle_control_fsm #(.STATE_W(W)) dut (
      .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .ImmSrc(ImmSrc), .RegWrite(RegWrite), .instr_done(instr_done),
      .illegal_op(illegal_op), .state_o(state_o)
   );

   // ---------------- scoreboard ----------------
   int errors = 0;
   int checks = 0;

   logic [W-1:0] exp_q[$];
   bit           mr_q[$];

   // per-cycle log of the most recent instruction, for directed spot checks
   logic [1:0] log_aluop [64];
   logic [1:0] log_srca  [64];
   logic [1:0] log_srcb  [64];
   logic [1:0] log_res   [64];
   logic       log_pcw   [64];
   logic       log_regw  [64];
   logic       log_memw  [64];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // instruction class: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 illegal
   function automatic int classify(input logic [6:0] o);
      case (o)
         OP_LW:   return 0;
         OP_SW:   return 1;
         OP_R:    return 2;
         OP_I:    return 3;
         OP_BEQ:  return 4;
         OP_JAL:  return 5;
         default: return 6;
      endcase
   endfunction

   function automatic logic [1:0] imm_of(input int cls);
      case (cls)
         1:       return 2'b01;
         4:       return 2'b10;
         5:       return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   // Expected state trace: fetch (with stalls), decode, class-specific tail.
   // mem_ready is low on every stall entry, high when a memory phase completes,
   // and random where it is meant to be ignored.
   task automatic build_trace(input int cls, input int fs, input int ms);
      exp_q.delete();
      mr_q.delete();
      repeat (fs) begin exp_q.push_back(W'(0)); mr_q.push_back(1'b0); end
      exp_q.push_back(W'(0)); mr_q.push_back(1'b1);
      exp_q.push_back(W'(1)); mr_q.push_back(1'($urandom_range(0, 1)));
      case (cls)
         0: begin
            exp_q.push_back(W'(2)); mr_q.push_back(1'($urandom_range(0, 1)));
            repeat (ms) begin exp_q.push_back(W'(3)); mr_q.push_back(1'b0); end
            exp_q.push_back(W'(3)); mr_q.push_back(1'b1);
            exp_q.push_back(W'(4)); mr_q.push_back(1'($urandom_range(0, 1)));
         end
         1: begin
            exp_q.push_back(W'(2)); mr_q.push_back(1'($urandom_range(0, 1)));
            repeat (ms) begin exp_q.push_back(W'(5)); mr_q.push_back(1'b0); end
            exp_q.push_back(W'(5)); mr_q.push_back(1'b1);
         end
         2, 3, 5: begin
            exp_q.push_back(cls == 2 ? W'(6) : (cls == 3 ? W'(8) : W'(9)));
            mr_q.push_back(1'($urandom_range(0, 1)));
            exp_q.push_back(W'(7)); mr_q.push_back(1'($urandom_range(0, 1)));
         end
         4: begin
            exp_q.push_back(W'(10)); mr_q.push_back(1'($urandom_range(0, 1)));
         end
         default: ;
      endcase
   endtask

   // ---------------- driver ----------------
   // Assumes the DUT is in FETCH at the next falling edge.
   task automatic run_instr(input logic [6:0] o, input logic z, input int fs, input int ms,
                            input string name);
      int cls, n, base;
      int n_irw, n_pcw, n_regw, n_memw;
      cls = classify(o);
      build_trace(cls, fs, ms);
      n = exp_q.size();
      n_irw = 0; n_pcw = 0; n_regw = 0; n_memw = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         op = o; Zero = z; mem_ready = mr_q[i];
         #1;
         check({name, " state"}, 32'(state_o), 32'(exp_q[i]));
         check({name, " instr_done"}, 32'(instr_done), 32'(i == n - 1));
         check({name, " illegal_op"}, 32'(illegal_op), 32'(cls == 6 && i == n - 1));
         check({name, " ImmSrc"}, 32'(ImmSrc), 32'(imm_of(cls)));
         n_irw  += int'(IRWrite);
         n_pcw  += int'(PCWrite);
         n_regw += int'(RegWrite);
         n_memw += int'(MemWrite);
         if (i < 64) begin
            log_aluop[i] = ALUOp;   log_srca[i] = ALUSrcA; log_srcb[i] = ALUSrcB;
            log_res[i]   = ResultSrc; log_pcw[i] = PCWrite; log_regw[i] = RegWrite;
            log_memw[i]  = MemWrite;
         end
      end
      case (cls)
         0, 1:    base = (cls == 0) ? 5 : 4;
         2, 3, 5: base = 4;
         4:       base = 3;
         default: base = 2;
      endcase
      check({name, " cycles"}, 32'(n), 32'(base + fs + ((cls <= 1) ? ms : 0)));
      check({name, " IRWrite count"}, 32'(n_irw), 32'd1);
      check({name, " PCWrite count"}, 32'(n_pcw),
            32'(1 + (cls == 5 ? 1 : 0) + ((cls == 4 && z) ? 1 : 0)));
      check({name, " RegWrite count"}, 32'(n_regw),
            32'((cls == 0 || cls == 2 || cls == 3 || cls == 5) ? 1 : 0));
      check({name, " MemWrite count"}, 32'(n_memw), 32'(cls == 1 ? ms + 1 : 0));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [6:0] ops [7];
      logic [6:0] rop;
      ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R; ops[3] = OP_I;
      ops[4] = OP_BEQ; ops[5] = OP_JAL; ops[6] = OP_BAD;

      // reset with mem_ready high: nothing may be written
      reset = 1'b1; mem_ready = 1'b1; op = OP_SW;
      repeat (3) @(posedge clk);
      #1;
      check("reset state", 32'(state_o), 32'd0);
      check("reset IRWrite", 32'(IRWrite), 32'd0);
      check("reset PCWrite", 32'(PCWrite), 32'd0);
      check("reset ALUSrcB", 32'(ALUSrcB), 32'h2);
      check("reset ResultSrc", 32'(ResultSrc), 32'h2);

      // walk an sw into a stalled MEMWRITE, then reset there
      @(negedge clk); reset = 1'b0; op = OP_SW; mem_ready = 1'b1;   // FETCH
      @(negedge clk); mem_ready = 1'b0;                              // DECODE
      @(negedge clk);                                                // MEMADR
      @(negedge clk); #1;                                            // MEMWRITE
      check("sw stall state", 32'(state_o), 32'd5);
      check("sw stall MemWrite", 32'(MemWrite), 32'd1);
      check("sw stall instr_done", 32'(instr_done), 32'd0);
      @(negedge clk); reset = 1'b1; #1;
      check("reset in MEMWRITE MemWrite", 32'(MemWrite), 32'd0);
      check("reset in MEMWRITE AdrSrc", 32'(AdrSrc), 32'd0);
      check("reset in MEMWRITE instr_done", 32'(instr_done), 32'd0);
      @(posedge clk); #1;
      check("state after reset edge", 32'(state_o), 32'd0);
      @(negedge clk); reset = 1'b0; mem_ready = 1'b1; #1;
      check("first fetch IRWrite", 32'(IRWrite), 32'd1);
      check("first fetch state", 32'(state_o), 32'd0);
      // return to a clean FETCH before the directed instructions
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;

      // directed instructions
      run_instr(OP_R, 1'b0, 0, 0, "R");
      check("R ALUOp in EXECUTER", 32'(log_aluop[2]), 32'h2);
      check("R PCWrite in FETCH", 32'(log_pcw[0]), 32'd1);
      check("R RegWrite in ALUWB", 32'(log_regw[3]), 32'd1);

      run_instr(OP_LW, 1'b0, 2, 3, "lw stalled");
      check("lw ResultSrc in MEMWB", 32'(log_res[9]), 32'h1);
      check("lw RegWrite in MEMWB", 32'(log_regw[9]), 32'd1);

      run_instr(OP_BEQ, 1'b1, 0, 0, "beq taken");
      check("beq taken PCWrite", 32'(log_pcw[2]), 32'd1);
      check("beq ALUOp", 32'(log_aluop[2]), 32'h1);

      run_instr(OP_BEQ, 1'b0, 0, 0, "beq not taken");
      check("beq not taken PCWrite", 32'(log_pcw[2]), 32'd0);

      run_instr(OP_JAL, 1'b0, 0, 0, "jal");
      check("jal PCWrite in JAL", 32'(log_pcw[2]), 32'd1);
      check("jal ALUSrcA", 32'(log_srca[2]), 32'h1);
      check("jal ALUSrcB", 32'(log_srcb[2]), 32'h2);

      run_instr(OP_BAD, 1'b0, 0, 0, "illegal");
      check("illegal decode writes", 32'({log_pcw[1], log_regw[1], log_memw[1]}), 32'd0);

      run_instr(OP_SW, 1'b0, 1, 2, "sw stalled");

      // randomized instruction stream
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 9) == 0) rop = 7'($urandom);
         else                          rop = ops[$urandom_range(0, 6)];
         run_instr(rop, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   $urandom_range(0, 3), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
